mac_chain_fir: RTL and testbench
================================

# mac_chain_fir

Parametrised successor to the weight-streaming MAC chain: a SIZE-tap systolic multiply-accumulate row in transposed (partial-sum-chain) form with stationary per-tap weights. It adds an accepted-sample handshake, output backpressure, warm-up tracking, cascade input, and a saturating rescaled output. It sits between the embedding/feature buffer and the downstream accumulator or activation stage. Several instances can be cascaded through `in_acc` and `out_acc`.

## Interface
- SIZE, 4: number of taps/PEs, ≥1
- BIT_WIDTH, 8: signed data and weight width
- ACC_WIDTH, 32: signed partial-sum width; must be ≥ 2*BIT_WIDTH+$clog2(SIZE)+1
- OUT_WIDTH, 16: signed width of the rescaled output, ≤ ACC_WIDTH
- SHIFT, 0: arithmetic right shift applied before output saturation
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- cfg_wr  in  1  weight write strobe
- cfg_addr  in  max(1,$clog2(SIZE))  tap index; writes with cfg_addr ≥ SIZE are ignored
- cfg_wdata  in  BIT_WIDTH  signed weight value
- clr  in  1  flushes partial sums, warm-up count and any pending output; weights are kept
- in_valid  in  1  sample offered
- in_ready  out  1  combinational: !clr && (!out_valid || out_ready)
- in_data  in  BIT_WIDTH  signed sample x
- in_acc  in  ACC_WIDTH  signed cascade term, sampled with in_data
- out_valid  out  1  result held in the output register
- out_ready  in  1  downstream accept
- out_acc  out  ACC_WIDTH  full-precision result y
- out_data  out  OUT_WIDTH  sat(y >>> SHIFT)
- out_sat  out  1  out_data was clipped
- warm  out  1  state == STEADY

## Operation
- Registers:
  - w[0..SIZE-1]
  - p[0..SIZE-2], the partial-sum chain
  - fill_cnt, range 0..SIZE-1
  - the output register
- Accept happens when in_valid && in_ready. On accept of sample x with cascade term c:
  - y = w[0]*x + p[0]
  - p[i] <= w[i+1]*x + p[i+1] for i < SIZE-2
  - p[SIZE-2] <= w[SIZE-1]*x + c
  - For SIZE = 1: y = w[0]*x + c.
- Result: y[t] = Σ_{i=0..SIZE-1} w[i]*x[t-i] + c[t-SIZE+1].
- The partial-sum chain advances only on accept. Gaps in in_valid do not disturb results.
- Products are sign-extended to ACC_WIDTH. Sums wrap modulo 2^ACC_WIDTH and never saturate internally.
- out_data:
  - Compute s = y >>> SHIFT (arithmetic, floor).
  - If s > 2^(OUT_WIDTH-1)-1, clip to that value and set out_sat = 1.
  - If s < -2^(OUT_WIDTH-1), clip to that value and set out_sat = 1.
  - Otherwise pass s through and set out_sat = 0.
- State machine (two states):
  - FILL:
    - Each accept increments fill_cnt. No output is produced.
    - The accept that takes fill_cnt to SIZE-1 moves the FSM to STEADY. That sample still produces no output.
    - SIZE = 1 enters STEADY directly from reset or clr.
  - STEADY: each accept loads y into the output register and sets out_valid = 1.
- Output register:
  - out_valid clears on out_ready when no new result is loaded in that cycle.
  - Accept while out_valid && out_ready: the new result replaces the old one and out_valid stays 1.
- Weight write:
  - Takes effect at the next edge.
  - A sample accepted in the same cycle uses the old weight.
  - Writes are allowed in any state.
- Priority: rst > clr > accept/cfg_wr.
  - clr:
    - zeroes p
    - zeroes fill_cnt
    - clears out_valid
    - returns the FSM to FILL
    - leaves w unchanged
    - blocks accept via in_ready
  - cfg_wr in the same cycle as clr is still performed.

## Timing
- Reset values:
  - w = 0, p = 0, fill_cnt = 0, state FILL
  - out_valid = 0, out_acc = 0, out_data = 0, out_sat = 0, warm = 0
  - in_ready = 1 in the first cycle after reset when clr = 0
- Latency: the result for a STEADY-state accept at edge N is valid after edge N, i.e. in cycle N+1.
- Throughput: one sample per cycle while out_ready = 1.
- Backpressure: when out_valid && !out_ready:
  - in_ready = 0
  - out_acc, out_data and out_sat are held stable
- No combinational path from in_valid to any output. in_ready depends only on clr, out_valid and out_ready.
- rst or clr mid-stream: the pending result is discarded, and the next SIZE-1 accepts are warm-up.

## Test plan
- Reset: assert rst for 2 cycles with in_valid = 1 -> out_valid = 0, out_acc = 0, out_data = 0, out_sat = 0, warm = 0, in_ready = 1, and no accept occurs.
- Basic FIR, SIZE = 4: set w = [1,2,3,4], stream x = 1,2,3,4,5 with in_acc = 0 -> no output for the first 3 samples, then out_acc = 20, then 30; out_data is equal to out_acc.
- Gaps and backpressure: repeat the basic FIR run with in_valid toggling and out_ready held low for 3 cycles -> outputs stay 20 then 30, in_ready = 0 while blocked, and the held values do not change.
- Saturation, OUT_WIDTH = 16, SHIFT = 0:
  - w = 127 in all taps, x = 127 ×4 -> out_acc = 64516, out_data = 32767, out_sat = 1.
  - x = -128 ×4 -> out_acc = -65024, out_data = -32768.
  - SHIFT = 2 with y = -5 -> out_data = -2.
- Cascade and clr:
  - in_acc = 100 on the first sample -> the first output is 120.
  - Pulse clr after the 5th sample -> out_valid drops and the next 3 accepts produce no output.
- Weight write on the accept edge: write w[0] = 9 in the same cycle as a STEADY accept of x = 1 -> that result uses the old w[0]; the following result uses 9.

Source files
------------

// File: rtl/mac_chain_fir.sv
// Transposed-form systolic FIR row with stationary per-tap weights, accept
// handshake, output backpressure, warm-up tracking, cascade input and saturating output.
module mac_chain_fir #(
  parameter int SIZE      = 4,
  parameter int BIT_WIDTH = 8,
  parameter int ACC_WIDTH = 32,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 0
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   cfg_wr,
  input  logic [((SIZE > 1) ? $clog2(SIZE) : 1)-1:0] cfg_addr,
  input  logic signed [BIT_WIDTH-1:0]            cfg_wdata,
  input  logic                                   clr,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic signed [BIT_WIDTH-1:0]            in_data,
  input  logic signed [ACC_WIDTH-1:0]            in_acc,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic signed [ACC_WIDTH-1:0]            out_acc,
  output logic signed [OUT_WIDTH-1:0]            out_data,
  output logic                                   out_sat,
  output logic                                   warm
);

  localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int PN = (SIZE > 1) ? SIZE - 1 : 1;
  localparam logic signed [ACC_WIDTH-1:0] OUT_MAX = ACC_WIDTH'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH-1:0] OUT_MIN = ~OUT_MAX;

  typedef enum logic [0:0] {FILL = 1'b0, STEADY = 1'b1} state_t;
  localparam state_t INIT_STATE = (SIZE == 1) ? STEADY : FILL;

  state_t                        state_q, state_d;
  logic [AW-1:0]                 fill_cnt_q, fill_cnt_d;
  logic signed [BIT_WIDTH-1:0]   w_q [SIZE];
  logic signed [BIT_WIDTH-1:0]   w_d [SIZE];
  logic signed [ACC_WIDTH-1:0]   p_q [PN];
  logic signed [ACC_WIDTH-1:0]   p_d [PN];
  logic signed [ACC_WIDTH-1:0]   chain_s [SIZE];
  logic signed [ACC_WIDTH-1:0]   y_s;
  logic                          out_valid_q, out_valid_d;
  logic signed [ACC_WIDTH-1:0]   out_acc_q, out_acc_d;
  logic signed [OUT_WIDTH-1:0]   out_data_q, out_data_d;
  logic                          out_sat_q, out_sat_d;
  logic                          accept_s;

  function automatic logic signed [ACC_WIDTH-1:0] mul_ext(
    input logic signed [BIT_WIDTH-1:0] a,
    input logic signed [BIT_WIDTH-1:0] b
  );
    logic signed [2*BIT_WIDTH-1:0] prod;
    prod = a * b;
    return ACC_WIDTH'(prod);
  endfunction

  // Returns {saturated, clipped value} of y >>> SHIFT.
  function automatic logic [OUT_WIDTH:0] rescale(input logic signed [ACC_WIDTH-1:0] y);
    logic signed [ACC_WIDTH-1:0] s;
    s = y >>> SHIFT;
    if (s > OUT_MAX) begin
      return {1'b1, OUT_MAX[OUT_WIDTH-1:0]};
    end else if (s < OUT_MIN) begin
      return {1'b1, OUT_MIN[OUT_WIDTH-1:0]};
    end else begin
      return {1'b0, s[OUT_WIDTH-1:0]};
    end
  endfunction

  assign in_ready  = !clr && (!out_valid_q || out_ready);
  assign accept_s  = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_acc   = out_acc_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign warm      = (state_q == STEADY);

  // The cascade term enters at the far end of the partial-sum chain.
  always_comb begin
    for (int i = 0; i < SIZE; i++) begin
      chain_s[i] = in_acc;
    end
    for (int i = 0; i < SIZE - 1; i++) begin
      chain_s[i] = p_q[i];
    end
    y_s = mul_ext(w_q[0], in_data) + chain_s[0];
  end

  always_comb begin
    w_d         = w_q;
    p_d         = p_q;
    fill_cnt_d  = fill_cnt_q;
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_acc_d   = out_acc_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;

    if (cfg_wr && (32'(cfg_addr) < SIZE)) begin
      w_d[cfg_addr] = cfg_wdata;
    end else begin
      w_d = w_q;
    end

    if (clr) begin
      for (int i = 0; i < PN; i++) begin
        p_d[i] = '0;
      end
      fill_cnt_d  = '0;
      state_d     = INIT_STATE;
      out_valid_d = 1'b0;
    end else if (accept_s) begin
      // Weights are read from the current registers, so a same-edge write lands afterwards.
      for (int i = 0; i < SIZE - 1; i++) begin
        p_d[i] = mul_ext(w_q[i+1], in_data) + chain_s[i+1];
      end
      case (state_q)
        FILL: begin
          fill_cnt_d  = fill_cnt_q + AW'(1);
          out_valid_d = 1'b0;
          if (fill_cnt_q == AW'(SIZE - 2)) begin
            state_d = STEADY;
          end else begin
            state_d = FILL;
          end
        end
        STEADY: begin
          out_valid_d             = 1'b1;
          out_acc_d               = y_s;
          {out_sat_d, out_data_d} = rescale(y_s);
        end
        default: begin
          state_d = INIT_STATE;
        end
      endcase
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SIZE; i++) begin
        w_q[i] <= '0;
      end
      for (int i = 0; i < PN; i++) begin
        p_q[i] <= '0;
      end
      fill_cnt_q  <= '0;
      state_q     <= INIT_STATE;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      w_q         <= w_d;
      p_q         <= p_d;
      fill_cnt_q  <= fill_cnt_d;
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_acc_q   <= out_acc_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

endmodule

// File: tb/tb_mac_chain_fir.sv
// Directed bench for mac_chain_fir: a default instance plus a SHIFT=2 instance
// sharing the same stimulus.
module tb_mac_chain_fir;

  logic               clk = 1'b0;
  logic               rst, cfg_wr, clr, in_valid, out_ready;
  logic [1:0]         cfg_addr;
  logic signed [7:0]  cfg_wdata, in_data;
  logic signed [31:0] in_acc;
  logic               in_ready, out_valid, out_sat, warm;
  logic signed [31:0] out_acc;
  logic signed [15:0] out_data;
  logic               sh_in_ready, sh_out_valid, sh_out_sat, sh_warm;
  logic signed [31:0] sh_out_acc;
  logic signed [15:0] sh_out_data;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mac_chain_fir u_dut (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .clr(clr), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_acc(in_acc),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc), .out_data(out_data),
    .out_sat(out_sat), .warm(warm)
  );

  mac_chain_fir #(.SHIFT(2)) u_dut_sh (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .clr(clr), .in_valid(in_valid), .in_ready(sh_in_ready), .in_data(in_data), .in_acc(in_acc),
    .out_valid(sh_out_valid), .out_ready(out_ready), .out_acc(sh_out_acc), .out_data(sh_out_data),
    .out_sat(sh_out_sat), .warm(sh_warm)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic signed [7:0] x, input logic signed [31:0] c);
    int k;
    in_valid = 1'b1;
    in_data  = x;
    in_acc   = c;
    k = 0;
    #1;
    while (!in_ready && k < 20) begin
      tick();
      k++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL push_timeout in_ready=%0b required=1", in_ready);
    end else begin
      tick();
    end
    in_valid = 1'b0;
    in_acc   = 32'sd0;
  endtask

  task automatic set_w(input logic [1:0] a, input logic signed [7:0] v);
    cfg_wr    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = v;
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic do_clr();
    clr      = 1'b1;
    in_valid = 1'b0;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_wr = 1'b0; cfg_addr = 2'd0; cfg_wdata = 8'sd0; clr = 1'b0;
    in_valid = 1'b1; in_data = 8'sd5; in_acc = 32'sd7; out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    in_acc = 32'sd0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got=%0b exp=0", out_valid); end
    n_checks++; if (out_acc !== 32'sd0) begin n_fail++; $display("FAIL rst_out_acc got=%0d exp=0", out_acc); end
    n_checks++; if (out_data !== 16'sd0) begin n_fail++; $display("FAIL rst_out_data got=%0d exp=0", out_data); end
    n_checks++; if (out_sat !== 1'b0) begin n_fail++; $display("FAIL rst_out_sat got=%0b exp=0", out_sat); end
    n_checks++; if (warm !== 1'b0) begin n_fail++; $display("FAIL rst_warm got=%0b exp=0", warm); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got=%0b exp=1", in_ready); end
    n_checks++; if (sh_in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_sh_in_ready got=%0b exp=1", sh_in_ready); end
    n_checks++; if (sh_warm !== 1'b0) begin n_fail++; $display("FAIL rst_sh_warm got=%0b exp=0", sh_warm); end
  endtask

  task automatic test_basic_fir();
    set_w(2'd0, 8'sd1); set_w(2'd1, 8'sd2); set_w(2'd2, 8'sd3); set_w(2'd3, 8'sd4);
    push(8'sd1, 32'sd0);
    push(8'sd2, 32'sd0);
    n_checks++; if (warm !== 1'b0) begin n_fail++; $display("FAIL fir_warm2 got=%0b exp=0", warm); end
    push(8'sd3, 32'sd0);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fir_valid3 got=%0b exp=0", out_valid); end
    n_checks++; if (warm !== 1'b1) begin n_fail++; $display("FAIL fir_warm3 got=%0b exp=1", warm); end
    push(8'sd4, 32'sd0);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL fir_valid4 got=%0b exp=1", out_valid); end
    n_checks++; if (out_acc !== 32'sd20) begin n_fail++; $display("FAIL fir_y4 got=%0d exp=20", out_acc); end
    n_checks++; if (out_data !== 16'sd20) begin n_fail++; $display("FAIL fir_d4 got=%0d exp=20", out_data); end
    push(8'sd5, 32'sd0);
    n_checks++; if (out_acc !== 32'sd30) begin n_fail++; $display("FAIL fir_y5 got=%0d exp=30", out_acc); end
    n_checks++; if (out_data !== 16'sd30) begin n_fail++; $display("FAIL fir_d5 got=%0d exp=30", out_data); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fir_drain got=%0b exp=0", out_valid); end
  endtask

  task automatic test_gaps_backpressure();
    do_clr();
    push(8'sd1, 32'sd0);
    tick();
    push(8'sd2, 32'sd0);
    tick();
    tick();
    push(8'sd3, 32'sd0);
    out_ready = 1'b0;
    push(8'sd4, 32'sd0);
    n_checks++; if (out_acc !== 32'sd20) begin n_fail++; $display("FAIL bp_y4 got=%0d exp=20", out_acc); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready got=%0b exp=0", in_ready); end
    in_valid = 1'b1; in_data = 8'sd5; in_acc = 32'sd0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid%0d got=%0b exp=1", k, out_valid); end
      n_checks++; if (out_acc !== 32'sd20) begin n_fail++; $display("FAIL bp_hold_acc%0d got=%0d exp=20", k, out_acc); end
      n_checks++; if (out_data !== 16'sd20) begin n_fail++; $display("FAIL bp_hold_data%0d got=%0d exp=20", k, out_data); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_ready%0d got=%0b exp=0", k, in_ready); end
    end
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got=%0b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_acc !== 32'sd30) begin n_fail++; $display("FAIL bp_y5 got=%0d exp=30", out_acc); end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid5 got=%0b exp=1", out_valid); end
  endtask

  task automatic test_saturation();
    do_clr();
    for (int i = 0; i < 4; i++) set_w(2'(i), 8'sd127);
    for (int i = 0; i < 4; i++) push(8'sd127, 32'sd0);
    n_checks++; if (out_acc !== 32'sd64516) begin n_fail++; $display("FAIL sat_pos_acc got=%0d exp=64516", out_acc); end
    n_checks++; if (out_data !== 16'sd32767) begin n_fail++; $display("FAIL sat_pos_data got=%0d exp=32767", out_data); end
    n_checks++; if (out_sat !== 1'b1) begin n_fail++; $display("FAIL sat_pos_flag got=%0b exp=1", out_sat); end
    n_checks++; if (sh_out_data !== 16'sd16129) begin n_fail++; $display("FAIL sat_pos_sh_data got=%0d exp=16129", sh_out_data); end
    n_checks++; if (sh_out_sat !== 1'b0) begin n_fail++; $display("FAIL sat_pos_sh_flag got=%0b exp=0", sh_out_sat); end
    for (int i = 0; i < 4; i++) push(-8'sd128, 32'sd0);
    n_checks++; if (out_acc !== -32'sd65024) begin n_fail++; $display("FAIL sat_neg_acc got=%0d exp=-65024", out_acc); end
    n_checks++; if (out_data !== 16'sh8000) begin n_fail++; $display("FAIL sat_neg_data got=%0d exp=-32768", out_data); end
    n_checks++; if (out_sat !== 1'b1) begin n_fail++; $display("FAIL sat_neg_flag got=%0b exp=1", out_sat); end
    n_checks++; if (sh_out_data !== -16'sd16256) begin n_fail++; $display("FAIL sat_neg_sh_data got=%0d exp=-16256", sh_out_data); end
    do_clr();
    set_w(2'd0, 8'sd1); set_w(2'd1, 8'sd0); set_w(2'd2, 8'sd0); set_w(2'd3, 8'sd0);
    push(8'sd0, 32'sd0); push(8'sd0, 32'sd0); push(8'sd0, 32'sd0); push(-8'sd5, 32'sd0);
    n_checks++; if (out_data !== -16'sd5) begin n_fail++; $display("FAIL shift0_data got=%0d exp=-5", out_data); end
    n_checks++; if (out_sat !== 1'b0) begin n_fail++; $display("FAIL shift0_flag got=%0b exp=0", out_sat); end
    n_checks++; if (sh_out_valid !== 1'b1) begin n_fail++; $display("FAIL shift2_valid got=%0b exp=1", sh_out_valid); end
    n_checks++; if (sh_out_acc !== -32'sd5) begin n_fail++; $display("FAIL shift2_acc got=%0d exp=-5", sh_out_acc); end
    n_checks++; if (sh_out_data !== -16'sd2) begin n_fail++; $display("FAIL shift2_data got=%0d exp=-2", sh_out_data); end
  endtask

  task automatic test_cascade_clr();
    do_clr();
    set_w(2'd0, 8'sd1); set_w(2'd1, 8'sd2); set_w(2'd2, 8'sd3); set_w(2'd3, 8'sd4);
    push(8'sd1, 32'sd100); push(8'sd2, 32'sd0); push(8'sd3, 32'sd0); push(8'sd4, 32'sd0);
    n_checks++; if (out_acc !== 32'sd120) begin n_fail++; $display("FAIL casc_y4 got=%0d exp=120", out_acc); end
    push(8'sd5, 32'sd0);
    n_checks++; if (out_acc !== 32'sd30) begin n_fail++; $display("FAIL casc_y5 got=%0d exp=30", out_acc); end
    clr = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL clr_ready got=%0b exp=0", in_ready); end
    tick();
    clr = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_valid got=%0b exp=0", out_valid); end
    n_checks++; if (warm !== 1'b0) begin n_fail++; $display("FAIL clr_warm got=%0b exp=0", warm); end
    for (int k = 0; k < 3; k++) begin
      push(8'(6 + k), 32'sd0);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_warmup%0d got=%0b exp=0", k, out_valid); end
    end
    push(8'sd9, 32'sd0);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL clr_resume_valid got=%0b exp=1", out_valid); end
    n_checks++; if (out_acc !== 32'sd70) begin n_fail++; $display("FAIL clr_resume_y got=%0d exp=70", out_acc); end
  endtask

  task automatic test_weight_write();
    cfg_wr = 1'b1; cfg_addr = 2'd0; cfg_wdata = 8'sd9;
    in_valid = 1'b1; in_data = 8'sd1; in_acc = 32'sd0;
    tick();
    cfg_wr = 1'b0;
    in_valid = 1'b0;
    n_checks++; if (out_acc !== 32'sd71) begin n_fail++; $display("FAIL wr_old_w got=%0d exp=71", out_acc); end
    push(8'sd1, 32'sd0);
    n_checks++; if (out_acc !== 32'sd70) begin n_fail++; $display("FAIL wr_new_w got=%0d exp=70", out_acc); end
  endtask

  initial begin
    test_reset();
    test_basic_fir();
    test_gaps_backpressure();
    test_saturation();
    test_cascade_clr();
    test_weight_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

endmodule
